// File: rtl/sfp_link_ctrl_pkg.sv
// sfp_link_pkg: shared constants for the SFP+ link sequencer.
// State encodings are plain localparams so the numeric values seen on
// link_state stay fixed for software and older tooling.
package sfp_link_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_DISABLED  = 3'd0;
   localparam logic [STATE_W-1:0] ST_ABSENT    = 3'd1;
   localparam logic [STATE_W-1:0] ST_PHY_RST   = 3'd2;
   localparam logic [STATE_W-1:0] ST_PLL_WAIT  = 3'd3;
   localparam logic [STATE_W-1:0] ST_LOCK_WAIT = 3'd4;
   localparam logic [STATE_W-1:0] ST_UP        = 3'd5;
   localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

endpackage

// File: rtl/sfp_link_ctrl_if.sv
// sfp_link_ctrl_if: cage pins and transceiver/PHY status/control for one port.
// master = link controller, slave = cage + PHY side.
interface sfp_link_ctrl_if;

   logic sfp_npres;
   logic sfp_los;
   logic sfp_tx_disable;
   logic qpll_lock;
   logic phy_rx_block_lock;
   logic phy_rx_high_ber;
   logic phy_rst;

   modport master (
      input  sfp_npres, sfp_los, qpll_lock, phy_rx_block_lock, phy_rx_high_ber,
      output sfp_tx_disable, phy_rst
   );

   modport slave (
      output sfp_npres, sfp_los, qpll_lock, phy_rx_block_lock, phy_rx_high_ber,
      input  sfp_tx_disable, phy_rst
   );

endinterface

// File: rtl/sfp_link_ctrl_debounce.sv
// sfp_link_debounce: 2-flop synchroniser followed by a stability filter.
// The filtered output only follows the synchronised input once it has
// disagreed with the current filtered value for CYCLES consecutive cycles.
module sfp_link_debounce #(
   parameter int   CYCLES    = 1024,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_i,
   output logic dout_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic          meta_q, sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // metastability guard for the asynchronous cage pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
      end
   end

   // count how long the input has disagreed; any agreement restarts the count
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q != filt_q) begin
         if (cnt_q == CW'(CYCLES - 1)) filt_d = sync_q;
         else                          cnt_d  = cnt_q + 1'b1;
      end
   end

   // filter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= RESET_VAL;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o = filt_q;

endmodule

// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: per-port SFP+ / 10GBASE-R bring-up and recovery sequencer.
// Optional statistics counters are built when SFP_LINK_CTRL_STATS_EN is defined.
// Every output comes straight from a flop; output flops are loaded from the
// next state so they change on the same edge as the state register.
module sfp_link_ctrl
   import sfp_link_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int RST_CYCLES      = 256,
   parameter int LOCK_TIMEOUT    = 1048576,
   parameter int BACKOFF_CYCLES  = 65536,
   parameter int CNT_W           = 21
`ifdef SFP_LINK_CTRL_STATS_EN
   , parameter int STAT_W        = 16
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ctrl_enable,
   sfp_link_ctrl_if.master    sfp,
   output logic               link_up,
   output logic [STATE_W-1:0] link_state,
   output logic               fault_pulse
`ifdef SFP_LINK_CTRL_STATS_EN
   , output logic [STAT_W-1:0] stat_retries
   , output logic [STAT_W-1:0] stat_link_drops
`endif
);

   logic               npres_f, los_f, present_f;
   logic [2:0]         meta_q, sync_q;
   logic               qpll_s, blk_s, ber_s;
   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               tx_dis_q, tx_dis_d;
   logic               phy_rst_q, phy_rst_d;
   logic               link_up_q, link_up_d;
   logic               fault_q, fault_d;

   sfp_link_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_npres (
      .clk(clk), .rst_n(rst_n), .din_i(sfp.sfp_npres), .dout_o(npres_f)
   );

   sfp_link_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_los (
      .clk(clk), .rst_n(rst_n), .din_i(sfp.sfp_los), .dout_o(los_f)
   );

   assign present_f = ~npres_f;

   // lock/BER flags only need synchronising, not filtering
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {sfp.phy_rx_high_ber, sfp.phy_rx_block_lock, sfp.qpll_lock};
         sync_q <= meta_q;
      end
   end

   assign qpll_s = sync_q[0];
   assign blk_s  = sync_q[1];
   assign ber_s  = sync_q[2];

   // next state: enable first, then presence/LOS, then per-state rules;
   // the timer reloads on any state change and otherwise counts down to 0
   always_comb begin
      state_d = state_q;
      timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
      if (!ctrl_enable) begin
         state_d = ST_DISABLED;
      end else if ((!present_f || los_f) &&
                   (state_q != ST_DISABLED) && (state_q != ST_ABSENT)) begin
         state_d = ST_ABSENT;
      end else begin
         case (state_q)
            ST_DISABLED:  state_d = ST_ABSENT;
            ST_ABSENT:    if (present_f && !los_f) state_d = ST_PHY_RST;
            ST_PHY_RST:   if (timer_q == '0) state_d = ST_PLL_WAIT;
            ST_PLL_WAIT: begin
               if (qpll_s)              state_d = ST_LOCK_WAIT;
               else if (timer_q == '0)  state_d = ST_FAULT;
            end
            ST_LOCK_WAIT: begin
               if (blk_s && !ber_s)                 state_d = ST_UP;
               else if ((timer_q == '0) || !qpll_s) state_d = ST_FAULT;
            end
            ST_UP:        if (!blk_s || ber_s || !qpll_s) state_d = ST_FAULT;
            ST_FAULT:     if (timer_q == '0) state_d = ST_PHY_RST;
            default:      state_d = ST_DISABLED;
         endcase
      end
      if (state_d != state_q) begin
         case (state_d)
            ST_PHY_RST:   timer_d = CNT_W'(RST_CYCLES - 1);
            ST_PLL_WAIT,
            ST_LOCK_WAIT: timer_d = CNT_W'(LOCK_TIMEOUT - 1);
            ST_FAULT:     timer_d = CNT_W'(BACKOFF_CYCLES - 1);
            default:      timer_d = '0;
         endcase
      end
   end

   // output values implied by the state being entered
   always_comb begin
      tx_dis_d  = (state_d == ST_DISABLED) || ((state_d == ST_ABSENT) && !present_f);
      phy_rst_d = (state_d == ST_DISABLED) || (state_d == ST_ABSENT) ||
                  (state_d == ST_PHY_RST)  || (state_d == ST_FAULT);
      link_up_d = (state_d == ST_UP);
      fault_d   = (state_d == ST_FAULT) && (state_q != ST_FAULT);
   end

   // state, timer and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_DISABLED;
         timer_q   <= '0;
         tx_dis_q  <= 1'b1;
         phy_rst_q <= 1'b1;
         link_up_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         tx_dis_q  <= tx_dis_d;
         phy_rst_q <= phy_rst_d;
         link_up_q <= link_up_d;
         fault_q   <= fault_d;
      end
   end

   assign sfp.sfp_tx_disable = tx_dis_q;
   assign sfp.phy_rst        = phy_rst_q;
   assign link_up            = link_up_q;
   assign link_state         = state_q;
   assign fault_pulse        = fault_q;

`ifdef SFP_LINK_CTRL_STATS_EN
   logic [STAT_W-1:0] retries_q, drops_q;

   // saturating event counters: every FAULT entry, and UP->FAULT exits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retries_q <= '0;
         drops_q   <= '0;
      end else begin
         if (fault_d && (retries_q != '1)) retries_q <= retries_q + 1'b1;
         if (fault_d && (state_q == ST_UP) && (drops_q != '1)) drops_q <= drops_q + 1'b1;
      end
   end

   assign stat_retries    = retries_q;
   assign stat_link_drops = drops_q;
`endif

endmodule
